gate_sequencer: RTL and testbench
=================================

# gate_sequencer

Run-state controller for the inverter gate path. It sequences bootstrap precharge, enables PWM, and latches hardware faults. It also owns the dead-time parameter: it shadows host writes and commits them to the dead-time generator only at safe points. It sits between host registers/fault inputs and the carrier, PWM and dead-time blocks, and drives their enable, precharge, `PRM_DEADTIME` and `LOAD` inputs.

## Interface
- `PRECHARGE_CYCLES`, 16'd1000: minimum precharge length in CLK cycles; legal range 1..65535.
- `DT_MIN`, 16'd20: lower clamp applied to requested dead time.
- `DT_DEFAULT`, 16'd50: dead-time value after reset.

Ports:
- `CLK`  in  1  system clock; the single clock domain.
- `ARESETN`  in  1  asynchronous, active-low reset.
- `START`  in  1  one-cycle request to start: IDLE→PRECHG.
- `STOP`  in  1  one-cycle request to stop: PRECHG/RUN→IDLE.
- `FAULT_N`  in  1  asynchronous hardware fault, active low, level.
- `FAULT_CLR`  in  1  one-cycle fault acknowledge.
- `CARRIER_PEAK`  in  1  one-cycle pulse at each carrier peak.
- `DT_REQ`  in  16  requested dead time, in CLK cycles.
- `DT_WR`  in  1  write strobe for `DT_REQ`.
- `PRM_DEADTIME`  out  16  active dead time, fed to the dead-time generator.
- `LOAD`  out  1  one-cycle force-load to the dead-time generator.
- `PWM_EN`  out  1  gate outputs enabled.
- `PRECHARGE`  out  1  forces low sides on and high sides off.
- `FAULT`  out  1  fault latched.
- `STATE`  out  2  IDLE=0, PRECHG=1, RUN=2, FLT=3.
- `DT_PENDING`  out  1  shadow value not yet committed.

## Operation
- Reset values: `STATE`=IDLE; `PWM_EN`=0; `PRECHARGE`=0; `FAULT`=0; `LOAD`=0; `DT_PENDING`=0; `PRM_DEADTIME`=`DT_DEFAULT`; shadow=`DT_DEFAULT`; precharge counter=0.
- `FAULT_N` passes through a 2-flop synchronizer whose flops reset to 1. "Fault" below means the synchronized value is 0.
- State transitions, highest priority first:
  - Fault → FLT, from any state.
  - IDLE: `STOP` → stay IDLE (STOP wins over a simultaneous START); `START` → PRECHG, counter cleared.
  - PRECHG: `STOP` → IDLE.
  - PRECHG: counter has reached `PRECHARGE_CYCLES`−1 and `CARRIER_PEAK`=1 → RUN.
  - RUN: `STOP` → IDLE. `START` is ignored.
  - FLT: `FAULT_CLR` with no fault → IDLE. `FAULT_CLR` while the fault persists is ignored. `START` and `STOP` are ignored.
- Precharge counter:
  - 16-bit; increments each cycle in PRECHG.
  - Saturates at `PRECHARGE_CYCLES`−1.
  - Cleared in every other state.
- Output decode (combinational from the state register): `PWM_EN`=(RUN), `PRECHARGE`=(PRECHG), `FAULT`=(FLT), `STATE`=state register.
- Dead-time shadow:
  - `DT_WR` captures max(`DT_REQ`, `DT_MIN`) into the shadow and sets `DT_PENDING`.
  - A second write before commit overwrites the shadow.
- Dead-time commit:
  - Happens on the first edge where `DT_PENDING`=1 and `CARRIER_PEAK`=0, in any state.
  - Effect: `PRM_DEADTIME` ← shadow and `DT_PENDING` cleared.
  - `DT_WR` in the same cycle as a commit: the old shadow is committed, the new value is captured, and `DT_PENDING` stays 1.
- `LOAD`:
  - Pulses for one cycle, on the cycle after a commit made in IDLE or FLT.
  - Never asserted for commits made in PRECHG or RUN; the downstream block takes those at its next `CARRIER_PEAK`.
  - `PRM_DEADTIME` therefore never changes on an edge where `CARRIER_PEAK`=1.

## Timing
- Fault latency: `FAULT_N` falls before edge k (setup met). It is synchronized at edges k and k+1; `STATE`=FLT and `PWM_EN`=0 after edge k+2.
- START latency: `START` high at edge k gives `PRECHARGE`=1 after edge k.
- Precharge length: RUN is entered at the first `CARRIER_PEAK` that occurs ≥`PRECHARGE_CYCLES` cycles into PRECHG. PRECHG always lasts ≥`PRECHARGE_CYCLES` cycles.
- STOP latency: `STOP` at edge k gives `PWM_EN`=0 after edge k.
- Commit latency: `DT_WR` at edge k with `CARRIER_PEAK`=0 in cycle k+1 gives `PRM_DEADTIME` updated after edge k+1. In IDLE/FLT, `LOAD`=1 during cycle k+2.
- Reset assertion mid-operation asynchronously forces every output to its reset value. The first edge after release starts in IDLE.

## Test plan
- Reset, then `START`, with `PRECHARGE_CYCLES`=8 and peaks every 20 cycles → PRECHG; RUN entered on the first peak ≥8 cycles later; `PWM_EN`=1 only in RUN.
- In RUN, drive `FAULT_N` low → FLT 3 edges later and `PWM_EN`=0. `FAULT_CLR` while `FAULT_N` is still low → stays FLT. Release `FAULT_N`, wait 2 cycles, then `FAULT_CLR` → IDLE.
- In IDLE, `DT_WR`, `DT_REQ`=100 → `PRM_DEADTIME`=100 after the next non-peak edge, `LOAD` pulses one cycle later, `DT_PENDING` 1→0.
- In RUN, `DT_WR`, `DT_REQ`=5, asserted in a cycle where `CARRIER_PEAK`=1 → clamped to 20; commit deferred past the peak cycle; no `LOAD`.
- `START` and `STOP` together in IDLE → stays IDLE. `STOP` during PRECHG → IDLE, counter cleared; a restart precharges the full 8 cycles again.
- Assert `ARESETN`=0 mid-RUN with a write pending → all outputs at reset values immediately; `PRM_DEADTIME`=50.

Source files
------------

// File: rtl/gate_sequencer.sv
// gate_sequencer
// Run-state controller for the inverter gate path. Sequences bootstrap
// precharge, enables PWM and latches hardware faults. Also owns the dead-time
// parameter: host writes land in a shadow register and are committed to the
// dead-time generator only on non-peak cycles.
//
// Ports
//   CLK, ARESETN   system clock, asynchronous active-low reset
//   START, STOP    one-cycle run requests
//   FAULT_N        asynchronous active-low fault level (synchronized here)
//   FAULT_CLR      one-cycle fault acknowledge
//   CARRIER_PEAK   one-cycle pulse at each carrier peak
//   DT_REQ, DT_WR  requested dead time and its write strobe
//   PRM_DEADTIME   active dead time to the dead-time generator
//   LOAD           one-cycle force-load to the dead-time generator
//   PWM_EN         gate outputs enabled (RUN)
//   PRECHARGE      low sides on / high sides off (PRECHG)
//   FAULT          fault latched (FLT)
//   STATE          IDLE=0, PRECHG=1, RUN=2, FLT=3
//   DT_PENDING     shadow value not yet committed
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | gates off, waiting for START
// PRECHG | bootstrap precharge, counting toward run entry
// RUN    | PWM enabled
// FLT    | fault latched, waits for FAULT_CLR with fault gone

module gate_sequencer #(
  parameter logic [15:0] PRECHARGE_CYCLES = 16'd1000,
  parameter logic [15:0] DT_MIN           = 16'd20,
  parameter logic [15:0] DT_DEFAULT       = 16'd50
) (
  input  logic        CLK,
  input  logic        ARESETN,
  input  logic        START,
  input  logic        STOP,
  input  logic        FAULT_N,
  input  logic        FAULT_CLR,
  input  logic        CARRIER_PEAK,
  input  logic [15:0] DT_REQ,
  input  logic        DT_WR,
  output logic [15:0] PRM_DEADTIME,
  output logic        LOAD,
  output logic        PWM_EN,
  output logic        PRECHARGE,
  output logic        FAULT,
  output logic [1:0]  STATE,
  output logic        DT_PENDING
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRECHG = 2'd1,
    ST_RUN    = 2'd2,
    ST_FLT    = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = PRECHARGE_CYCLES - 16'd1;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sync1_q, sync2_q;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] prm_q, prm_d;
  logic        pending_q, pending_d;
  logic        load_q, load_d;

  logic        fault_sync;
  logic        commit;
  logic [15:0] dt_clamped;

  assign fault_sync = ~sync2_q;
  assign dt_clamped = (DT_REQ < DT_MIN) ? DT_MIN : DT_REQ;
  // Commits avoid peak cycles so the generator never sees a change at the
  // instant it samples the parameter.
  assign commit     = pending_q & ~CARRIER_PEAK;

  // State and datapath registers
  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      shadow_q  <= DT_DEFAULT;
      prm_q     <= DT_DEFAULT;
      pending_q <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sync1_q   <= FAULT_N;
      sync2_q   <= sync1_q;
      shadow_q  <= shadow_d;
      prm_q     <= prm_d;
      pending_q <= pending_d;
      load_q    <= load_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (fault_sync) begin
      state_d = ST_FLT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!STOP && START) state_d = ST_PRECHG;
        end
        ST_PRECHG: begin
          if (STOP)                                   state_d = ST_IDLE;
          else if ((cnt_q == CNT_LAST) && CARRIER_PEAK) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (STOP) state_d = ST_IDLE;
        end
        ST_FLT: begin
          if (FAULT_CLR) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Precharge counter and dead-time shadow/commit
  always_comb begin
    cnt_d = 16'd0;
    if (state_q == ST_PRECHG) begin
      cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 16'd1;
    end

    // A write coinciding with a commit still commits the old shadow; the
    // new value is captured and stays pending.
    shadow_d  = DT_WR ? dt_clamped : shadow_q;
    prm_d     = commit ? shadow_q : prm_q;
    pending_d = DT_WR ? 1'b1 : (commit ? 1'b0 : pending_q);
    // While gating is active the generator picks up the new value at its
    // next peak on its own; a force-load is only needed when it is idle.
    load_d    = commit && ((state_q == ST_IDLE) || (state_q == ST_FLT));
  end

  // Output decode
  always_comb begin
    PWM_EN       = (state_q == ST_RUN);
    PRECHARGE    = (state_q == ST_PRECHG);
    FAULT        = (state_q == ST_FLT);
    STATE        = state_q;
    PRM_DEADTIME = prm_q;
    LOAD         = load_q;
    DT_PENDING   = pending_q;
  end

endmodule

// File: tb/tb_gate_sequencer.sv
module tb_gate_sequencer;

  logic        CLK = 1'b0;
  logic        ARESETN;
  logic        START, STOP, FAULT_N, FAULT_CLR, CARRIER_PEAK, DT_WR;
  logic [15:0] DT_REQ;
  logic [15:0] PRM_DEADTIME;
  logic        LOAD, PWM_EN, PRECHARGE, FAULT, DT_PENDING;
  logic [1:0]  STATE;

  int checks = 0;
  int errors = 0;

  gate_sequencer #(
    .PRECHARGE_CYCLES(16'd8),
    .DT_MIN(16'd20),
    .DT_DEFAULT(16'd50)
  ) dut (
    .CLK(CLK), .ARESETN(ARESETN), .START(START), .STOP(STOP),
    .FAULT_N(FAULT_N), .FAULT_CLR(FAULT_CLR), .CARRIER_PEAK(CARRIER_PEAK),
    .DT_REQ(DT_REQ), .DT_WR(DT_WR), .PRM_DEADTIME(PRM_DEADTIME),
    .LOAD(LOAD), .PWM_EN(PWM_EN), .PRECHARGE(PRECHARGE), .FAULT(FAULT),
    .STATE(STATE), .DT_PENDING(DT_PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {14'd0, STATE}, 16'd0);
    check({tag, "_pwm"},   {15'd0, PWM_EN}, 16'd0);
    check({tag, "_prech"}, {15'd0, PRECHARGE}, 16'd0);
    check({tag, "_fault"}, {15'd0, FAULT}, 16'd0);
    check({tag, "_load"},  {15'd0, LOAD}, 16'd0);
    check({tag, "_pend"},  {15'd0, DT_PENDING}, 16'd0);
    check({tag, "_prm"},   PRM_DEADTIME, 16'd50);
  endtask

  initial begin
    ARESETN = 1'b0; START = 0; STOP = 0; FAULT_N = 1; FAULT_CLR = 0;
    CARRIER_PEAK = 0; DT_WR = 0; DT_REQ = 16'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge CLK);
    ARESETN = 1'b1;
    tick();
    check("idle_after_reset", {14'd0, STATE}, 16'd0);

    // Start and precharge; an early peak must not end precharge
    START = 1; tick(); START = 0;
    check("start_state", {14'd0, STATE}, 16'd1);
    check("start_prech", {15'd0, PRECHARGE}, 16'd1);
    check("start_pwm", {15'd0, PWM_EN}, 16'd0);
    tick(4);
    CARRIER_PEAK = 1; tick(); CARRIER_PEAK = 0;
    check("early_peak_state", {14'd0, STATE}, 16'd1);
    tick(19);
    check("prech_wait_state", {14'd0, STATE}, 16'd1);
    check("prech_wait_pwm", {15'd0, PWM_EN}, 16'd0);
    CARRIER_PEAK = 1; tick(); CARRIER_PEAK = 0;
    check("run_state", {14'd0, STATE}, 16'd2);
    check("run_pwm", {15'd0, PWM_EN}, 16'd1);
    check("run_prech", {15'd0, PRECHARGE}, 16'd0);

    // Clamped write during a peak in RUN; commit deferred, no LOAD
    DT_REQ = 16'd5; DT_WR = 1; CARRIER_PEAK = 1; tick(); DT_WR = 0;
    check("run_wr_pend", {15'd0, DT_PENDING}, 16'd1);
    check("run_wr_prm", PRM_DEADTIME, 16'd50);
    tick();
    check("run_defer_prm", PRM_DEADTIME, 16'd50);
    check("run_defer_pend", {15'd0, DT_PENDING}, 16'd1);
    CARRIER_PEAK = 0; tick();
    check("run_commit_prm", PRM_DEADTIME, 16'd20);
    check("run_commit_pend", {15'd0, DT_PENDING}, 16'd0);
    check("run_commit_load", {15'd0, LOAD}, 16'd0);
    tick();
    check("run_no_load", {15'd0, LOAD}, 16'd0);

    // Fault in RUN: FLT after third edge
    FAULT_N = 0; tick(2);
    check("fault_lat_run", {14'd0, STATE}, 16'd2);
    tick();
    check("fault_state", {14'd0, STATE}, 16'd3);
    check("fault_pwm", {15'd0, PWM_EN}, 16'd0);
    check("fault_flag", {15'd0, FAULT}, 16'd1);
    FAULT_CLR = 1; tick(); FAULT_CLR = 0;
    check("clr_while_fault", {14'd0, STATE}, 16'd3);
    START = 1; tick(); START = 0;
    check("start_in_flt", {14'd0, STATE}, 16'd3);
    FAULT_N = 1; tick(2);
    check("flt_hold", {14'd0, STATE}, 16'd3);
    FAULT_CLR = 1; tick(); FAULT_CLR = 0;
    check("clr_state", {14'd0, STATE}, 16'd0);
    check("clr_fault", {15'd0, FAULT}, 16'd0);

    // IDLE write: commit next edge, LOAD the cycle after
    DT_REQ = 16'd100; DT_WR = 1; tick(); DT_WR = 0;
    check("idle_wr_pend", {15'd0, DT_PENDING}, 16'd1);
    check("idle_wr_prm", PRM_DEADTIME, 16'd20);
    check("idle_wr_load", {15'd0, LOAD}, 16'd0);
    tick();
    check("idle_commit_prm", PRM_DEADTIME, 16'd100);
    check("idle_commit_pend", {15'd0, DT_PENDING}, 16'd0);
    check("idle_load", {15'd0, LOAD}, 16'd1);
    tick();
    check("idle_load_end", {15'd0, LOAD}, 16'd0);

    // Back-to-back writes: old shadow committed, new one stays pending
    DT_REQ = 16'd200; DT_WR = 1; tick();
    DT_REQ = 16'd300; tick(); DT_WR = 0;
    check("b2b_prm1", PRM_DEADTIME, 16'd200);
    check("b2b_pend1", {15'd0, DT_PENDING}, 16'd1);
    check("b2b_load1", {15'd0, LOAD}, 16'd1);
    tick();
    check("b2b_prm2", PRM_DEADTIME, 16'd300);
    check("b2b_pend2", {15'd0, DT_PENDING}, 16'd0);
    check("b2b_load2", {15'd0, LOAD}, 16'd1);
    tick();
    check("b2b_load_end", {15'd0, LOAD}, 16'd0);

    // Clamp boundary: 19 -> 20
    DT_REQ = 16'd19; DT_WR = 1; tick(); DT_WR = 0; tick();
    check("clamp_19", PRM_DEADTIME, 16'd20);
    tick();

    // START and STOP together in IDLE
    START = 1; STOP = 1; tick(); START = 0; STOP = 0;
    check("start_stop_idle", {14'd0, STATE}, 16'd0);

    // STOP during precharge, then full-length restart
    START = 1; tick(); START = 0;
    tick(4);
    STOP = 1; tick(); STOP = 0;
    check("stop_prech", {14'd0, STATE}, 16'd0);
    check("stop_prech_out", {15'd0, PRECHARGE}, 16'd0);
    START = 1; tick(); START = 0;
    tick(6);
    CARRIER_PEAK = 1; tick();
    check("restart_peak_7th", {14'd0, STATE}, 16'd1);
    tick(); CARRIER_PEAK = 0;
    check("restart_peak_8th", {14'd0, STATE}, 16'd2);

    // START ignored in RUN, STOP leaves immediately
    START = 1; tick(); START = 0;
    check("start_in_run", {14'd0, STATE}, 16'd2);
    STOP = 1; tick(); STOP = 0;
    check("stop_run_pwm", {15'd0, PWM_EN}, 16'd0);
    check("stop_run_state", {14'd0, STATE}, 16'd0);

    // Back to RUN, then reset with a write pending
    START = 1; tick(); START = 0;
    tick(7);
    CARRIER_PEAK = 1; tick();
    check("rerun_state", {14'd0, STATE}, 16'd2);
    DT_REQ = 16'd77; DT_WR = 1; tick(); DT_WR = 0;
    check("rst_pre_pend", {15'd0, DT_PENDING}, 16'd1);
    ARESETN = 0;
    #1;
    check_reset_outputs("async_rst");
    CARRIER_PEAK = 0;
    @(negedge CLK);
    ARESETN = 1;
    tick();
    check("post_rst_state", {14'd0, STATE}, 16'd0);
    check("post_rst_prm", PRM_DEADTIME, 16'd50);
    check("post_rst_pend", {15'd0, DT_PENDING}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
